// File: rtl/alu_multiciclo.sv
// Registered multi-cycle ALU: single-cycle add/xor/sub/slt plus iterative shift-add multiply
// and restoring divide behind a start/busy/done handshake.
module alu_multiciclo #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       Controle,
    input  logic [WIDTH-1:0] BussA,
    input  logic [WIDTH-1:0] BussB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Opt,
    output logic [WIDTH-1:0] OptHi,
    output logic             COT,
    output logic             ovflw,
    output logic             ngt,
    output logic             zero,
    output logic             divzero
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpXor = 3'b001;
    localparam logic [2:0] OpSub = 3'b010;
    localparam logic [2:0] OpSlt = 3'b011;
    localparam logic [2:0] OpMul = 3'b100;
    localparam logic [2:0] OpDiv = 3'b101;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  work_hi_q, work_hi_d, work_lo_q, work_lo_d;

    logic [WIDTH-1:0]  opt_d, opthi_d;
    logic              cot_d, ovflw_d, ngt_d, zero_d, divzero_d;

    // Single-cycle ALU path, evaluated straight from the inputs at the accepting edge
    logic [WIDTH:0]    add_full, sub_full;
    logic              add_ovf, sub_ovf;
    logic [WIDTH-1:0]  alu_opt, alu_hi;
    logic              alu_cot, alu_ovf, alu_dz;

    always_comb begin
        add_full = {1'b0, BussA} + {1'b0, BussB};
        sub_full = {1'b0, BussA} - {1'b0, BussB};
        add_ovf  = (BussA[WIDTH-1] == BussB[WIDTH-1]) && (add_full[WIDTH-1] != BussA[WIDTH-1]);
        sub_ovf  = (BussA[WIDTH-1] != BussB[WIDTH-1]) && (sub_full[WIDTH-1] != BussA[WIDTH-1]);

        alu_opt = '0;
        alu_hi  = '0;
        alu_cot = 1'b0;
        alu_ovf = 1'b0;
        alu_dz  = 1'b0;
        case (Controle)
            OpAdd: begin
                alu_opt = add_full[WIDTH-1:0];
                alu_cot = add_full[WIDTH];
                alu_ovf = add_ovf;
            end
            OpXor: alu_opt = BussA ^ BussB;
            OpSub: begin
                alu_opt = sub_full[WIDTH-1:0];
                alu_cot = sub_full[WIDTH];
                alu_ovf = sub_ovf;
            end
            OpSlt: begin
                // Sign of the difference corrected by overflow gives the true signed compare
                alu_opt = {{(WIDTH-1){1'b0}}, sub_full[WIDTH-1] ^ sub_ovf};
                alu_cot = sub_full[WIDTH];
                alu_ovf = sub_ovf;
            end
            OpDiv: begin
                alu_opt = '1;
                alu_hi  = BussA;
                alu_dz  = 1'b1;
            end
            default: ;
        endcase
    end

    // One iteration of shift-add multiply: multiplier lives in work_lo, partial sum in work_hi
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH-1:0]  mul_hi_next, mul_lo_next;

    always_comb begin
        mul_sum     = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, a_q} : '0);
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], work_lo_q[WIDTH-1:1]};
    end

    // One iteration of restoring divide: dividend shifts out of work_lo MSB-first,
    // quotient bits shift in at the bottom, partial remainder in work_hi
    logic [WIDTH:0]    div_shift;
    logic              div_ge;
    logic [WIDTH-1:0]  div_sub, div_hi_next, div_lo_next;

    always_comb begin
        div_shift   = {work_hi_q, work_lo_q[WIDTH-1]};
        div_ge      = div_shift >= {1'b0, b_q};
        div_sub     = div_shift[WIDTH-1:0] - b_q;
        div_hi_next = div_ge ? div_sub : div_shift[WIDTH-1:0];
        div_lo_next = {work_lo_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        opt_d     = Opt;
        opthi_d   = OptHi;
        cot_d     = COT;
        ovflw_d   = ovflw;
        ngt_d     = ngt;
        zero_d    = zero;
        divzero_d = divzero;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    op_d  = Controle;
                    a_d   = BussA;
                    b_d   = BussB;
                    cnt_d = '0;
                    if (Controle == OpMul) begin
                        state_d   = StCalc;
                        work_hi_d = '0;
                        work_lo_d = BussB;
                    end else if (Controle == OpDiv && BussB != '0) begin
                        state_d   = StCalc;
                        work_hi_d = '0;
                        work_lo_d = BussA;
                    end else begin
                        state_d   = StDone;
                        opt_d     = alu_opt;
                        opthi_d   = alu_hi;
                        cot_d     = alu_cot;
                        ovflw_d   = alu_ovf;
                        ngt_d     = alu_opt[WIDTH-1];
                        zero_d    = (alu_opt == '0);
                        divzero_d = alu_dz;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StCalc: begin
                cnt_d = cnt_q + CNTW'(1);
                if (op_q == OpMul) begin
                    work_hi_d = mul_hi_next;
                    work_lo_d = mul_lo_next;
                end else begin
                    work_hi_d = div_hi_next;
                    work_lo_d = div_lo_next;
                end
                if (cnt_q == CNTW'(WIDTH - 1)) begin
                    state_d   = StDone;
                    opt_d     = work_lo_d;
                    opthi_d   = work_hi_d;
                    cot_d     = 1'b0;
                    ovflw_d   = 1'b0;
                    ngt_d     = work_lo_d[WIDTH-1];
                    zero_d    = (op_q == OpMul) ? ({work_hi_d, work_lo_d} == '0)
                                                : (work_lo_d == '0);
                    divzero_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            Opt       <= '0;
            OptHi     <= '0;
            COT       <= 1'b0;
            ovflw     <= 1'b0;
            ngt       <= 1'b0;
            zero      <= 1'b0;
            divzero   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            Opt       <= opt_d;
            OptHi     <= opthi_d;
            COT       <= cot_d;
            ovflw     <= ovflw_d;
            ngt       <= ngt_d;
            zero      <= zero_d;
            divzero   <= divzero_d;
        end
    end

    assign busy = (state_q == StCalc);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed bench for alu_multiciclo: a 32-bit instance for the main plan and an 8-bit
// instance for the narrow multiply/xor cases.
module tb_alu_multiciclo;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  Controle;
    logic [31:0] BussA, BussB;
    logic        busy, done, COT, ovflw, ngt, zero, divzero;
    logic [31:0] Opt, OptHi;

    logic        w8_start;
    logic [2:0]  w8_op;
    logic [7:0]  w8_a, w8_b, w8_opt, w8_hi;
    logic        w8_busy, w8_done, w8_cot, w8_ovflw, w8_ngt, w8_zero, w8_divzero;

    int checks = 0;
    int errors = 0;
    int n, nb;

    always #5 clk = ~clk;

    alu_multiciclo #(.WIDTH(32), .CNTW(6)) dut (
        .clk(clk), .reset(reset), .start(start), .Controle(Controle),
        .BussA(BussA), .BussB(BussB), .busy(busy), .done(done),
        .Opt(Opt), .OptHi(OptHi), .COT(COT), .ovflw(ovflw), .ngt(ngt),
        .zero(zero), .divzero(divzero)
    );

    alu_multiciclo #(.WIDTH(8), .CNTW(4)) dut8 (
        .clk(clk), .reset(reset), .start(w8_start), .Controle(w8_op),
        .BussA(w8_a), .BussB(w8_b), .busy(w8_busy), .done(w8_done),
        .Opt(w8_opt), .OptHi(w8_hi), .COT(w8_cot), .ovflw(w8_ovflw), .ngt(w8_ngt),
        .zero(w8_zero), .divzero(w8_divzero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        Controle = op;
        BussA    = a;
        BussB    = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; Controle = 3'd0; BussA = '0; BussB = '0;
        w8_start = 1'b0; w8_op = 3'd0; w8_a = '0; w8_b = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_opt", {32'd0, Opt}, 64'd0);
        chk("reset_flags", {busy, done, COT, ovflw, ngt, zero, divzero}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // ADD signed overflow
        issue(3'b000, 32'h7FFF_FFFF, 32'd1);
        chk("add_done", done, 1);
        chk("add_opt", Opt, 64'h8000_0000);
        chk("add_flags", {COT, ovflw, ngt, zero}, 4'b0110);
        @(negedge clk);
        chk("add_done_pulse", {done, busy}, 0);

        // ADD unsigned carry wrapping to zero
        issue(3'b000, 32'hFFFF_FFFF, 32'd1);
        chk("addc_opt", Opt, 0);
        chk("addc_flags", {COT, ovflw, ngt, zero}, 4'b1001);

        // Reserved opcode
        issue(3'b110, 32'd5, 32'd5);
        chk("rsv_out", {Opt, OptHi}, 0);
        chk("rsv_zero", zero, 1);

        // SUB then SLT issued back-to-back in the DONE cycle
        issue(3'b010, 32'd5, 32'd5);
        chk("sub_opt", Opt, 0);
        chk("sub_flags", {done, zero, COT}, 3'b110);
        issue(3'b011, 32'h8000_0000, 32'd1);
        chk("slt_done", done, 1);
        chk("slt_opt", Opt, 1);
        chk("slt_flags", {ovflw, COT}, 2'b10);

        // MUL with a start pulse mid-CALC that must be ignored
        issue(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n = 0; nb = 0;
        while (!done && n < 200) begin
            if (busy) nb++;
            if (n == 5) begin
                start = 1'b1; Controle = 3'b000; BussA = 32'd1; BussB = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("mul_latency", n, 32);
        chk("mul_busy_cycles", nb, 32);
        chk("mul_hi", OptHi, 64'hFFFF_FFFE);
        chk("mul_lo", Opt, 64'h0000_0001);
        chk("mul_flags", {COT, ovflw, zero, busy}, 0);
        @(negedge clk);
        chk("mul_no_queue", {done, busy}, 0);

        // DIV 100/7
        issue(3'b101, 32'd100, 32'd7);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("div_latency", n, 32);
        chk("div_quot", Opt, 14);
        chk("div_rem", OptHi, 2);
        chk("div_dz", divzero, 0);

        // DIV by zero: single cycle
        issue(3'b101, 32'd9, 32'd0);
        chk("dz_done", {done, busy}, 2'b10);
        chk("dz_opt", Opt, 64'hFFFF_FFFF);
        chk("dz_hi", OptHi, 9);
        chk("dz_flag", divzero, 1);

        // Next ordinary op clears divzero
        issue(3'b001, 32'h0000_F0F0, 32'h0000_0F0F);
        chk("xor_opt", Opt, 64'h0000_FFFF);
        chk("xor_hi_dz", {OptHi, 1'b0, divzero}, 0);

        // Asynchronous reset while a MUL is in flight
        issue(3'b100, 32'd3, 32'd4);
        repeat (10) @(negedge clk);
        chk("rst_busy_before", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_out", {Opt, OptHi}, 0);
        chk("rst_async_flags", {busy, done, COT, ovflw, ngt, zero, divzero}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(3'b000, 32'd2, 32'd3);
        chk("post_rst_add", {done, Opt}, {1'b1, 32'd5});

        // 8-bit instance
        w8_start = 1'b1; w8_op = 3'b100; w8_a = 8'hFF; w8_b = 8'h02;
        @(negedge clk);
        w8_start = 1'b0;
        n = 0;
        while (!w8_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("w8_mul_latency", n, 8);
        chk("w8_mul", {w8_hi, w8_opt}, 16'h01FE);
        w8_start = 1'b1; w8_op = 3'b001; w8_a = 8'hAA; w8_b = 8'hFF;
        @(negedge clk);
        w8_start = 1'b0;
        chk("w8_xor", {w8_done, w8_opt}, {1'b1, 8'h55});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
- Parametrised, registered ALU that extends the combinational add/sub/xor/slt ALU.
- Adds iterative unsigned multiply (shift-add) and unsigned restoring divide, driven by a start/busy/done handshake.
- Sits in the multi-cycle datapath's execute stage; the control FSM issues one operation and waits for done.
- All results and flags are registered and held stable until the next accepted operation.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNTW, 6, iteration counter width; must satisfy 2**CNTW > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request; sampled on clk when state is IDLE or DONE.
- Controle  input  3  operation: 000 ADD, 001 XOR, 010 SUB, 011 SLT, 100 MUL, 101 DIV, 110/111 reserved.
- BussA  input  WIDTH  operand A; captured on accepted start.
- BussB  input  WIDTH  operand B; captured on accepted start.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; result valid.
- Opt  output  WIDTH  result / product low half / quotient.
- OptHi  output  WIDTH  product high half / remainder; 0 for ALU ops.
- COT  output  1  carry (ADD) or borrow (SUB/SLT); 0 otherwise.
- ovflw  output  1  signed overflow (ADD/SUB/SLT); 0 otherwise.
- ngt  output  1  Opt[WIDTH-1].
- zero  output  1  Opt==0 (MUL: full 2*WIDTH product ==0).
- divzero  output  1  DIV with BussB==0.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, Opt=0, OptHi=0, COT=0, ovflw=0, ngt=0, zero=0, divzero=0; counter and operand registers cleared. Any in-flight MUL/DIV is abandoned.
- FSM states: IDLE, CALC, DONE.
- Accepting start: start=1 at edge k in IDLE or DONE accepts the op and latches Controle, BussA and BussB.
  - start in CALC is ignored and not queued; inputs may change freely during CALC.
- ADD/XOR/SUB/SLT/reserved: result and flags are computed and registered at edge k, and state goes to DONE. done=1 in the cycle after edge k (latency 1); busy is never asserted.
- MUL and DIV (non-zero divisor): at edge k go to CALC with counter=0. Each edge performs one iteration. The counter advances 0..WIDTH-1, and after the iteration at counter WIDTH-1 the FSM goes to DONE. done is high after edge k+WIDTH; busy is high after edges k..k+WIDTH-1.
- DIV by zero: behaves like an ALU op.
  - Latency 1.
  - Opt=all ones, OptHi=BussA, divzero=1.
- DONE lasts exactly one cycle, then goes to IDLE unless a new start is accepted there (back-to-back issue allowed).
- Outputs hold their last value through IDLE and CALC. They update only when the FSM enters DONE.
- Arithmetic:
  - ADD: Opt=A+B mod 2^WIDTH, COT=carry out.
  - SUB: Opt=A-B, COT=1 iff A<B unsigned (borrow).
  - ovflw = carry into MSB XOR carry out of MSB.
  - SLT: Opt=1 if A<B signed, else 0; correct under overflow (sign of difference XOR ovflw). COT and ovflw reflect the subtraction.
  - XOR: Opt=A^B.
  - Reserved: Opt=0, zero=1.
- MUL: unsigned, {OptHi,Opt}=A*B; shift-add with one partial product per cycle.
- DIV: unsigned restoring; one quotient bit per cycle, MSB first. Opt=A/B, OptHi=A%B.
- divzero clears on the next completed non-divide-by-zero operation.

Test Plan:
- Issue ADD A=0x7FFFFFFF, B=1 -> done 1 cycle later; Opt=0x80000000, ovflw=1, ngt=1, COT=0, zero=0.
- Issue SUB A=5, B=5, then back-to-back SLT A=0x80000000, B=1 issued in the DONE cycle:
  - SUB -> Opt=0, zero=1, COT=0.
  - SLT -> Opt=1, ovflw=1, COT=0.
- Issue MUL A=0xFFFFFFFF, B=0xFFFFFFFF -> busy for 32 cycles, done at cycle 33. Check OptHi=0xFFFFFFFE, Opt=0x00000001. Pulse start mid-CALC and confirm it is ignored.
- Issue DIV A=100, B=7 -> after 32 cycles Opt=14, OptHi=2, divzero=0. Then DIV A=9, B=0 -> latency 1; Opt=0xFFFFFFFF, OptHi=9, divzero=1.
- Start MUL, assert reset at CALC cycle 10 -> all outputs 0 immediately (asynchronous); a fresh ADD 2+3 afterwards gives Opt=5 with 1-cycle latency.
- WIDTH=8 instance: MUL 0xFF*0x02 -> OptHi=0x01, Opt=0xFE after 8 iteration cycles; XOR 0xAA^0xFF -> Opt=0x55.
